// File: rtl/contador_bcd_varredura.sv
// contador_bcd_varredura: multi-digit BCD up/down counter with a scanned
// output for a time-multiplexed 7-segment display.
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-high
//   habilita     count enable; gates the count prescaler
//   sentido      1 = up, 0 = down
//   zera         synchronous clear of count and count prescaler
//   carrega      synchronous parallel load (digits above 9 saturate to 9)
//   valor_carga  load value, digit k at [4k+3:4k]
//   contagem     registered count, same packing as valor_carga
//   bcd          digit currently selected by the scan (combinational)
//   digito_sel   one-hot digit enable, bit k selects digit k
//   estouro      one-cycle pulse after a wrap (overflow or underflow)
module contador_bcd_varredura #(
  parameter int unsigned DIGITOS   = 4,
  parameter int unsigned DIV_CONTA = 50_000_000,
  parameter int unsigned DIV_VARRE = 50_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   habilita,
  input  logic                   sentido,
  input  logic                   zera,
  input  logic                   carrega,
  input  logic [4*DIGITOS-1:0]   valor_carga,
  output logic [4*DIGITOS-1:0]   contagem,
  output logic [3:0]             bcd,
  output logic [DIGITOS-1:0]     digito_sel,
  output logic                   estouro
);

  localparam int unsigned LARG = 4 * DIGITOS;
  localparam int unsigned PC_W = (DIV_CONTA > 1) ? $clog2(DIV_CONTA) : 1;
  localparam int unsigned PV_W = (DIV_VARRE > 1) ? $clog2(DIV_VARRE) : 1;
  localparam int unsigned IX_W = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;
  localparam logic [PC_W-1:0] PC_FIM = PC_W'(DIV_CONTA - 1);
  localparam logic [PV_W-1:0] PV_FIM = PV_W'(DIV_VARRE - 1);
  localparam logic [IX_W-1:0] IX_FIM = IX_W'(DIGITOS - 1);

  logic [PC_W-1:0]    pre_conta;
  logic [PV_W-1:0]    pre_varre;
  logic [IX_W-1:0]    indice;
  logic [LARG-1:0]    conta_prox;
  logic [LARG-1:0]    carga_sat;
  logic [DIGITOS-1:0] sel_rot;
  logic               vai;
  logic               virada;
  logic               tick;
  logic               passo;

  assign tick  = habilita && (pre_conta == PC_FIM);
  assign passo = (pre_varre == PV_FIM);

  // Ripple carry/borrow through the digits; a carry out of the top digit is a wrap.
  always_comb begin
    conta_prox = contagem;
    vai        = 1'b1;
    for (int k = 0; k < int'(DIGITOS); k++) begin
      if (vai) begin
        if (sentido) begin
          if (contagem[4*k +: 4] >= 4'd9) begin
            conta_prox[4*k +: 4] = 4'd0;
          end else begin
            conta_prox[4*k +: 4] = contagem[4*k +: 4] + 4'd1;
            vai                  = 1'b0;
          end
        end else begin
          if (contagem[4*k +: 4] == 4'd0) begin
            conta_prox[4*k +: 4] = 4'd9;
          end else begin
            conta_prox[4*k +: 4] = contagem[4*k +: 4] - 4'd1;
            vai                  = 1'b0;
          end
        end
      end
    end
    virada = vai;
  end

  // Load value with each digit clamped to 9.
  always_comb begin
    carga_sat = '0;
    for (int k = 0; k < int'(DIGITOS); k++) begin
      carga_sat[4*k +: 4] = (valor_carga[4*k +: 4] > 4'd9) ? 4'd9 : valor_carga[4*k +: 4];
    end
  end

  // Scan mux and left rotation of the digit enable (modulo index keeps DIGITOS=1 legal).
  always_comb begin
    bcd     = 4'd0;
    sel_rot = '0;
    for (int k = 0; k < int'(DIGITOS); k++) begin
      sel_rot[k] = digito_sel[(k + int'(DIGITOS) - 1) % int'(DIGITOS)];
      if (indice == IX_W'(k)) bcd = contagem[4*k +: 4];
    end
  end

  // Count prescaler, count register and wrap pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_conta <= '0;
      contagem  <= '0;
      estouro   <= 1'b0;
    end else begin
      if (zera) begin
        pre_conta <= '0;
      end else if (habilita) begin
        pre_conta <= tick ? '0 : pre_conta + PC_W'(1);
      end
      estouro <= 1'b0;
      if (zera) begin
        contagem <= '0;
      end else if (carrega) begin
        contagem <= carga_sat;
      end else if (tick) begin
        contagem <= conta_prox;
        estouro  <= virada;
      end
    end
  end

  // Free-running scan prescaler and digit selection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_varre  <= '0;
      indice     <= '0;
      digito_sel <= DIGITOS'(1);
    end else begin
      pre_varre <= passo ? '0 : pre_varre + PV_W'(1);
      if (passo) begin
        indice     <= (indice == IX_FIM) ? '0 : indice + IX_W'(1);
        digito_sel <= sel_rot;
      end
    end
  end

endmodule

// File: tb/tb_contador_bcd_varredura.sv
// Directed bench for contador_bcd_varredura (DIGITOS=2, DIV_VARRE=3) with a
// second instance at DIV_CONTA=4 for the prescaler step.
module tb_contador_bcd_varredura;

  logic       clk;
  logic       rst;
  logic       habilita;
  logic       sentido;
  logic       zera;
  logic       carrega;
  logic [7:0] valor_carga;
  logic [7:0] contagem;
  logic [3:0] bcd;
  logic [1:0] digito_sel;
  logic       estouro;
  logic [7:0] contagem4;
  logic [3:0] bcd4;
  logic [1:0] digito_sel4;
  logic       estouro4;

  int n_checks = 0;
  int n_pass   = 0;
  int n_bordas = 0;
  int n_mod    = 0;
  int n_ant    = 0;

  typedef struct {
    string      tag;
    logic [7:0] conta;
    logic       est;
    logic       chk4;
    logic [7:0] conta4;
  } esperado_t;

  esperado_t fila[$];

  contador_bcd_varredura #(.DIGITOS(2), .DIV_CONTA(1), .DIV_VARRE(3)) dut (
    .clk(clk), .rst(rst), .habilita(habilita), .sentido(sentido), .zera(zera),
    .carrega(carrega), .valor_carga(valor_carga), .contagem(contagem), .bcd(bcd),
    .digito_sel(digito_sel), .estouro(estouro)
  );

  contador_bcd_varredura #(.DIGITOS(2), .DIV_CONTA(4), .DIV_VARRE(3)) dut4 (
    .clk(clk), .rst(rst), .habilita(habilita), .sentido(sentido), .zera(zera),
    .carrega(carrega), .valor_carga(valor_carga), .contagem(contagem4), .bcd(bcd4),
    .digito_sel(digito_sel4), .estouro(estouro4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release, used to predict the scan phase.
  always @(posedge clk or posedge rst) begin
    if (rst) n_bordas <= 0;
    else     n_bordas <= n_bordas + 1;
  end

  function automatic logic [7:0] para_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic verifica(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic empurra(input string tag, input logic [7:0] conta, input logic est,
                         input logic chk4, input logic [7:0] conta4);
    esperado_t e;
    e.tag = tag; e.conta = conta; e.est = est; e.chk4 = chk4; e.conta4 = conta4;
    fila.push_back(e);
  endtask

  // One clock: pop the prediction for this edge and compare all outputs.
  task automatic ciclo();
    esperado_t e;
    int ix;
    @(posedge clk);
    #1;
    if (fila.size() == 0) begin
      n_checks++;
      $error("FAIL scoreboard: observed=empty expected=entry");
    end else begin
      e  = fila.pop_front();
      ix = (n_bordas / 3) % 2;
      verifica({e.tag, ".contagem"},   16'(contagem),   16'(e.conta));
      verifica({e.tag, ".estouro"},    16'(estouro),    16'(e.est));
      verifica({e.tag, ".digito_sel"}, 16'(digito_sel), (ix == 1) ? 16'h2 : 16'h1);
      verifica({e.tag, ".bcd"},        16'(bcd),        (ix == 1) ? 16'(e.conta[7:4]) : 16'(e.conta[3:0]));
      if (e.chk4) verifica({e.tag, ".contagem4"}, 16'(contagem4), 16'(e.conta4));
    end
  endtask

  initial begin
    logic hab_seq [6];
    logic [7:0] c4;
    hab_seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    rst = 1'b1; habilita = 1'b0; sentido = 1'b1; zera = 1'b0; carrega = 1'b0;
    valor_carga = 8'h00;
    #12;
    verifica("reset.contagem",    16'(contagem),    16'h00);
    verifica("reset.bcd",         16'(bcd),         16'h0);
    verifica("reset.digito_sel",  16'(digito_sel),  16'h1);
    verifica("reset.estouro",     16'(estouro),     16'h0);
    verifica("reset.contagem4",   16'(contagem4),   16'h00);
    verifica("reset.bcd4",        16'(bcd4),        16'h0);
    verifica("reset.digito_sel4", 16'(digito_sel4), 16'h1);
    verifica("reset.estouro4",    16'(estouro4),    16'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Up count over a full wrap.
    habilita = 1'b1; sentido = 1'b1; n_mod = 0;
    repeat (100) begin
      n_ant = n_mod;
      n_mod = (n_mod + 1) % 100;
      empurra("up", para_bcd(n_mod), n_ant == 99, 1'b0, 8'h00);
      ciclo();
    end

    // Down count: underflow then ten more ticks.
    sentido = 1'b0;
    repeat (11) begin
      n_ant = n_mod;
      n_mod = (n_mod + 99) % 100;
      empurra("down", para_bcd(n_mod), n_ant == 0, 1'b0, 8'h00);
      ciclo();
    end

    // Priority and load saturation.
    habilita = 1'b0; carrega = 1'b1; valor_carga = 8'h4F;
    empurra("load4F", 8'h49, 1'b0, 1'b0, 8'h00); ciclo();
    zera = 1'b1;
    empurra("zera_over_load", 8'h00, 1'b0, 1'b0, 8'h00); ciclo();
    zera = 1'b0; habilita = 1'b1; sentido = 1'b1; valor_carga = 8'h25;
    empurra("load_over_tick", 8'h25, 1'b0, 1'b0, 8'h00); ciclo();
    valor_carga = 8'hA3;
    empurra("loadA3", 8'h93, 1'b0, 1'b0, 8'h00); ciclo();
    carrega = 1'b0; habilita = 1'b0;
    empurra("hold", 8'h93, 1'b0, 1'b0, 8'h00); ciclo();

    // Scan with a frozen count.
    carrega = 1'b1; valor_carga = 8'h37;
    empurra("scan_load", 8'h37, 1'b0, 1'b0, 8'h00); ciclo();
    carrega = 1'b0;
    repeat (9) begin
      empurra("scan", 8'h37, 1'b0, 1'b0, 8'h00);
      ciclo();
    end

    // Prescaler: reset both instances, then gated enables.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    sentido = 1'b1; n_mod = 0; c4 = 8'h00;
    for (int i = 0; i < 6; i++) begin
      habilita = hab_seq[i];
      if (hab_seq[i]) n_mod = n_mod + 1;
      if (i == 5) c4 = 8'h01;
      empurra("presc", para_bcd(n_mod), 1'b0, 1'b1, c4);
      ciclo();
    end
    habilita = 1'b0;
    empurra("presc_hold", para_bcd(n_mod), 1'b0, 1'b1, 8'h01); ciclo();

    // Async reset between edges with a nonzero count.
    carrega = 1'b1; valor_carga = 8'h57;
    empurra("pre_rst", 8'h57, 1'b0, 1'b0, 8'h00); ciclo();
    carrega = 1'b0;
    #3; rst = 1'b1; #1;
    verifica("arst.contagem",   16'(contagem),   16'h00);
    verifica("arst.bcd",        16'(bcd),        16'h0);
    verifica("arst.digito_sel", 16'(digito_sel), 16'h1);
    verifica("arst.estouro",    16'(estouro),    16'h0);
    @(posedge clk); #1; rst = 1'b0;

    // Async reset while the wrap pulse is high.
    habilita = 1'b1; sentido = 1'b1; carrega = 1'b1; valor_carga = 8'h99;
    empurra("load99", 8'h99, 1'b0, 1'b0, 8'h00); ciclo();
    carrega = 1'b0;
    empurra("wrap", 8'h00, 1'b1, 1'b0, 8'h00); ciclo();
    #3; rst = 1'b1; #1;
    verifica("arst_est.estouro",  16'(estouro),  16'h0);
    verifica("arst_est.contagem", 16'(contagem), 16'h00);
    habilita = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    empurra("post_rst", 8'h00, 1'b0, 1'b0, 8'h00); ciclo();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
